// File: rtl/count_pkg.sv
// count_pkg: shared types and constants for the count serializer.
//   state_t       - serializer FSM state encoding
//   WIDTH_DEFAULT - default width of the captured count word
package count_pkg;

  localparam int unsigned WIDTH_DEFAULT = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    SHIFT = 2'd2,
    DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/count_serializer_if.sv
// count_serializer_if: control and serial-stream signals of the count serializer.
//   count_in    - parallel count word to snapshot
//   load_req    - one-cycle request to snapshot count_in and start a frame
//   ser_ready   - downstream accepts the current serial bit
//   clr_ovr     - clears the sticky overrun flag
//   ser_out     - current serial bit
//   ser_valid   - ser_out carries a valid bit
//   frame_start - start bit is being presented
//   busy        - a frame is in progress (any state but IDLE)
//   done        - one-cycle end-of-frame pulse
//   overrun     - sticky flag: load_req seen while busy
// master = requester/consumer side, slave = serializer side.
interface count_serializer_if
  import count_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEFAULT
) ();

  logic [WIDTH-1:0] count_in;
  logic             load_req;
  logic             ser_ready;
  logic             clr_ovr;
  logic             ser_out;
  logic             ser_valid;
  logic             frame_start;
  logic             busy;
  logic             done;
  logic             overrun;

  modport master (
    output count_in, load_req, ser_ready, clr_ovr,
    input  ser_out, ser_valid, frame_start, busy, done, overrun
  );

  modport slave (
    input  count_in, load_req, ser_ready, clr_ovr,
    output ser_out, ser_valid, frame_start, busy, done, overrun
  );

endinterface

// File: rtl/count_serializer_shift_reg_ld.sv
// shift_reg_ld: loadable left-shift register exposing its MSB.
//   clk        - system clock
//   rst_n      - asynchronous active-low reset (clears the register)
//   load_i     - parallel load of data_i (has priority over shift)
//   shift_en_i - shift left by one, zero fill
//   data_i     - parallel load value
//   msb_o      - current most significant bit
module shift_reg_ld #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_i,
  input  logic             shift_en_i,
  input  logic [WIDTH-1:0] data_i,
  output logic             msb_o
);

  logic [WIDTH-1:0] data_q;
  logic [WIDTH-1:0] data_d;

  always_comb begin
    data_d = data_q;
    if (load_i) begin
      data_d = data_i;
    end else if (shift_en_i) begin
      data_d = {data_q[WIDTH-2:0], 1'b0};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q <= '0;
    end else begin
      data_q <= data_d;
    end
  end

  assign msb_o = data_q[WIDTH-1];

endmodule

// File: rtl/count_serializer.sv
// count_serializer: snapshots a parallel count word and sends it as a serial
// frame (start bit '1', then WIDTH data bits MSB first) under a valid/ready
// handshake.
//   clk   - system clock
//   rst_n - asynchronous active-low reset
//   bus   - count_serializer_if slave modport (see interface for signals)
module count_serializer
  import count_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEFAULT
) (
  input  logic                 clk,
  input  logic                 rst_n,
  count_serializer_if.slave    bus
);

  localparam int unsigned     CW   = $clog2(WIDTH + 1);
  localparam logic [CW-1:0]   LAST = CW'(WIDTH - 1);

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          ovr_q, ovr_d;

  logic load_c;
  logic shift_c;
  logic msb;

  logic ser_out_c;
  logic ser_valid_c;
  logic frame_start_c;
  logic busy_c;
  logic done_c;

  shift_reg_ld #(
    .WIDTH(WIDTH)
  ) u_sreg (
    .clk       (clk),
    .rst_n     (rst_n),
    .load_i    (load_c),
    .shift_en_i(shift_c),
    .data_i    (bus.count_in),
    .msb_o     (msb)
  );

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    ovr_d         = ovr_q;
    load_c        = 1'b0;
    shift_c       = 1'b0;
    ser_out_c     = 1'b0;
    ser_valid_c   = 1'b0;
    frame_start_c = 1'b0;
    busy_c        = 1'b0;
    done_c        = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (bus.load_req) begin
          load_c  = 1'b1;
          cnt_d   = '0;
          state_d = START;
        end
      end
      START: begin
        busy_c        = 1'b1;
        ser_valid_c   = 1'b1;
        frame_start_c = 1'b1;
        ser_out_c     = 1'b1;
        if (bus.ser_ready) begin
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        busy_c      = 1'b1;
        ser_valid_c = 1'b1;
        ser_out_c   = msb;
        if (bus.ser_ready) begin
          shift_c = 1'b1;
          cnt_d   = cnt_q + CW'(1);
          // cnt_q counts completed data transfers; this one is the last.
          if (cnt_q == LAST) begin
            state_d = DONE;
          end
        end
      end
      DONE: begin
        busy_c  = 1'b1;
        done_c  = 1'b1;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Set is evaluated last so a simultaneous overrun beats clr_ovr.
    if (bus.clr_ovr) begin
      ovr_d = 1'b0;
    end
    if (bus.load_req && (state_q != IDLE)) begin
      ovr_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ovr_q   <= ovr_d;
    end
  end

  assign bus.ser_out     = ser_out_c;
  assign bus.ser_valid   = ser_valid_c;
  assign bus.frame_start = frame_start_c;
  assign bus.busy        = busy_c;
  assign bus.done        = done_c;
  assign bus.overrun     = ovr_q;

endmodule

// File: doc/count_serializer.md
COUNT_SERIALIZER -- requirements
Module: count_serializer

Interface
REQ-001 Parameter WIDTH, default 16: bit width of the captured count word; legal range 2..32.
REQ-002 clk  input  1  single system clock; all state updates on posedge clk.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 count_in  input  WIDTH  parallel count value to be read out.
REQ-005 load_req  input  1  single-cycle request to snapshot count_in and start a frame.
REQ-006 ser_ready  input  1  downstream accepts the current serial bit this cycle.
REQ-007 clr_ovr  input  1  clears the overrun flag.
REQ-008 ser_out  output  1  current serial bit.
REQ-009 ser_valid  output  1  ser_out holds a valid bit.
REQ-010 frame_start  output  1  high while the start bit is presented.
REQ-011 busy  output  1  high in every state except IDLE.
REQ-012 done  output  1  one-cycle pulse after the last data bit is accepted.
REQ-013 overrun  output  1  sticky flag: load_req arrived while busy.

Function
REQ-014 The FSM SHALL have exactly the states IDLE, START, SHIFT and DONE.
REQ-015 In IDLE with load_req=1, the block SHALL latch count_in into the shift register on that edge and enter START.
REQ-016 A frame SHALL consist of one start bit (value 1) followed by WIDTH data bits, MSB first.
REQ-017 A bit SHALL transfer only on a cycle with ser_valid=1 and ser_ready=1.
REQ-018 While ser_ready=0, the block SHALL hold ser_out, state and the bit counter stable.
REQ-019 In START, ser_valid=1, frame_start=1 and ser_out=1; on transfer the state SHALL become SHIFT.
REQ-020 In SHIFT, ser_out SHALL equal the shift-register MSB.
REQ-021 On each SHIFT transfer, the register SHALL shift left by one and the bit counter SHALL increment.
REQ-022 After the WIDTH-th transfer, the state SHALL become DONE.
REQ-023 In DONE, ser_valid=0 and done=1 for exactly one cycle, then the state SHALL return to IDLE unconditionally.
REQ-024 A load_req in any state other than IDLE SHALL be ignored for data purposes and SHALL set overrun on the next edge.
REQ-025 With clr_ovr=1 and a new overrun event in the same cycle, the set SHALL win.
REQ-026 count_in changes after the snapshot edge SHALL NOT affect the frame in progress.
REQ-027 The bit counter SHALL be $clog2(WIDTH+1) bits wide and SHALL never wrap within a frame.
REQ-028 Minimum latency from load_req to done: WIDTH+2 cycles with ser_ready held at 1.
REQ-029 In IDLE and DONE, ser_out SHALL be 0.

Reset
REQ-030 While rst_n=0, the block SHALL be in IDLE with shift register = 0 and bit counter = 0.
REQ-031 While rst_n=0, ser_out, ser_valid, frame_start, busy, done and overrun SHALL all be 0.
REQ-032 Reset asserted mid-frame SHALL abort the frame immediately, with no done pulse.
REQ-033 After reset deassertion, the first load_req SHALL start a fresh frame.

Structure
REQ-034 Package count_pkg SHALL hold the state enum type (IDLE, START, SHIFT, DONE) and the WIDTH default constant.
REQ-035 The loadable shift register SHALL be a sub-module named shift_reg_ld, with ports: parallel load, shift enable, MSB out and the same async active-low reset.
REQ-036 FSM, bit counter and overrun flag SHALL reside in count_serializer.

Verification (WIDTH=8)
REQ-037 Basic frame: count_in=8'hA5, load_req pulse, ser_ready=1 -> ser_out 1,1,0,1,0,0,1,0,1 on consecutive cycles; done 10 cycles after load_req.
REQ-038 Back-pressure: as REQ-037 with ser_ready=0 for 3 cycles mid-SHIFT -> same bit sequence, ser_out held stable during stall, done delayed exactly 3 cycles.
REQ-039 Overrun: second load_req 4 cycles into a frame -> frame data unchanged, overrun=1 next cycle; clr_ovr pulse -> overrun=0; clr_ovr coincident with a new overrun -> overrun stays 1.
REQ-040 Snapshot: count_in=8'h0F at load, then 8'hFF the next cycle -> transmitted data 0,0,0,0,1,1,1,1.
REQ-041 Reset mid-frame: rst_n low during the 5th data bit -> all outputs 0 immediately, no done; new load_req with 8'h81 -> correct full frame.
REQ-042 Back-to-back: load_req in the cycle after done -> second frame starts with no overrun; load_req during DONE -> overrun=1.
